mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 20, width of all address and length fields.
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 Parameter MEM_DEPTH, default 20'h96000, number of valid words; legal addresses are 0 .. MEM_DEPTH-1.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1, system clock; all block registers update on the rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, single-cycle request to begin a copy.
REQ-008 Port src_addr, input, ADDR_W, first source word address; sampled only when a start is accepted.
REQ-009 Port dst_addr, input, ADDR_W, first destination word address; sampled only when a start is accepted.
REQ-010 Port length, input, ADDR_W, number of words to copy; sampled only when a start is accepted.
REQ-011 Port busy, output, 1, high from the cycle after an accepted start until the transfer ends.
REQ-012 Port done, output, 1, one-cycle pulse marking the end of a transfer.
REQ-013 Port err, output, 1, range error flag.
REQ-014 Port mem_address, output, ADDR_W, address to data_memory.
REQ-015 Port mem_wren, output, 1, write enable to data_memory.
REQ-016 Port mem_data, output, DATA_W, write data to data_memory.
REQ-017 Port mem_q, input, DATA_W, read data from data_memory.

Function
REQ-018 Memory timing: data_memory is clocked on ~clk; mem_q for an address presented with mem_wren=0 in cycle N SHALL be captured at the rising edge that ends cycle N.
REQ-019 FSM states SHALL be IDLE, CHECK, RD, WR and FIN.
REQ-020 IDLE: start=1 latches src_addr, dst_addr and length, clears err, and moves to CHECK; start while not IDLE SHALL be ignored.
REQ-021 CHECK (1 cycle):
- If length=0, go to FIN with err=0.
- If src_addr+length > MEM_DEPTH or dst_addr+length > MEM_DEPTH, set err=1 and go to FIN; evaluate the sums at ADDR_W+1 bits so no wrap is possible.
- Otherwise go to RD.
REQ-022 RD: drive mem_address=current source address with mem_wren=0; at the end of the cycle capture mem_q into the data register and go to WR.
REQ-023 WR: drive mem_address=current destination address, mem_wren=1 and mem_data=captured word for exactly one cycle; then increment both addresses, decrement the remaining count, and go to RD if the count is nonzero, else FIN.
REQ-024 Throughput SHALL be exactly 2 cycles per word; a transfer of L>0 words SHALL take 2L+2 cycles from the start edge to the done pulse, inclusive of CHECK and FIN.
REQ-025 FIN: done=1 for one cycle, then IDLE; busy SHALL be 1 in CHECK, RD and WR and 0 in FIN and IDLE.
REQ-026 err SHALL remain set until the next accepted start; an err transfer SHALL issue no memory writes.
REQ-027 mem_wren SHALL be 1 only in WR; mem_address and mem_data SHALL be 0 in IDLE, CHECK and FIN.
REQ-028 The copy SHALL proceed in ascending address order; overlapping ranges with dst_addr <= src_addr SHALL copy correctly, and dst_addr > src_addr overlap is unsupported (result undefined).
REQ-029 Outputs SHALL be registered; mem_data SHALL be driven from the data register, never combinationally from mem_q.

Reset
REQ-030 rst=1 SHALL immediately force IDLE with busy=0, done=0, err=0, mem_wren=0, mem_address=0, mem_data=0, and all counters and registers cleared.
REQ-031 A reset asserted mid-transfer SHALL abort it without a done pulse; words already written remain written.
REQ-032 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 Basic copy: preload 0x00000..0x00003 with 11,22,33,44; start with src=0, dst=0x100, length=4 -> 0x100..0x103 read back 11,22,33,44; done pulses exactly 10 cycles after the start edge; exactly 4 mem_wren pulses.
REQ-034 Upper boundary: src=0x95FFE, dst=0x10, length=2 -> copy succeeds with err=0; src=0x95FFF, length=2 -> err=1, done pulses 2 cycles after the start edge, no mem_wren.
REQ-035 Zero length: length=0 -> done after 2 cycles, err=0, mem_wren never asserted, busy high for 1 cycle.
REQ-036 Start while busy: a second start in the middle of a length-8 copy -> ignored; only the original 8 words are written and exactly one done pulse occurs.
REQ-037 Reset mid-transfer: assert rst during the 3rd WR of a length-6 copy -> mem_wren drops within the same cycle, busy=0, no done; a following copy with length=1 completes normally in 4 cycles.

Source files
------------

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-by-word memory copy engine with range checking,
// one read and one write cycle per word against a negedge-clocked RAM.
module mem_copy_dma #(
  parameter int              ADDR_W    = 20,
  parameter int              DATA_W    = 8,
  parameter logic [ADDR_W:0] MEM_DEPTH = 'h96000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);
  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              err_q, err_d, busy_q, busy_d, done_q, done_d, mem_wren_q, mem_wren_d;
  logic [ADDR_W:0]   src_end, dst_end;
  logic              ovf;
  // one extra bit so that address + length can never wrap
  assign src_end = {1'b0, src_q} + {1'b0, cnt_q};
  assign dst_end = {1'b0, dst_q} + {1'b0, cnt_q};
  assign ovf     = (src_end > MEM_DEPTH) || (dst_end > MEM_DEPTH);
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CHECK;
        src_d   = src_addr;
        dst_d   = dst_addr;
        cnt_d   = length;
        err_d   = 1'b0;
      end
      CHECK: begin
        state_d = (cnt_q == '0 || ovf) ? FIN : RD;
        err_d   = (cnt_q != '0) && ovf;
      end
      RD: state_d = WR;
      WR: begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? FIN : RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so they register alongside it
    busy_d        = (state_d == CHECK) || (state_d == RD) || (state_d == WR);
    done_d        = state_d == FIN;
    mem_wren_d    = state_d == WR;
    mem_address_d = (state_d == RD) ? src_d : (state_d == WR) ? dst_q : '0;
    mem_data_d    = (state_d == WR) ? mem_q : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_wren_q    <= mem_wren_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign mem_wren    = mem_wren_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: table-driven and randomized checks of mem_copy_dma against
// a word-array reference copy and cycle counts derived from the transfer length.
module tb_mem_copy_dma;
  localparam int DEPTH = 'h96000;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [19:0] src_addr = '0, dst_addr = '0, length = '0;
  logic        busy, done, err, mem_wren;
  logic [19:0] mem_address;
  logic [7:0]  mem_data, mem_q;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  int checks = 0, errors = 0;

  mem_copy_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .err(err), .mem_address(mem_address),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  typedef struct {
    int src, dst, len;
    int exp_err, exp_cyc, exp_wr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_xfer(input int src, input int dst, input int len,
                          input int exp_err, input int exp_cyc, input int exp_wr,
                          input int inj_n);
    int first_done = 0, dones = 0, wrs = 0, busys = 0, err_at = -1, bad = 0;
    start = 1'b1; src_addr = 20'(src); dst_addr = 20'(dst); length = 20'(len);
    for (int n = 1; n <= exp_cyc + 4; n++) begin
      @(negedge clk);
      start = (n == inj_n);
      if (n == inj_n) begin
        src_addr = 20'h00050; dst_addr = 20'h00900; length = 20'd3;
      end
      if (done) begin
        dones++;
        if (first_done == 0) begin first_done = n; err_at = int'(err); end
      end
      if (mem_wren) wrs++;
      if (busy) busys++;
    end
    start = 1'b0;
    chk("done_cycle", first_done, exp_cyc);
    chk("done_pulses", dones, 1);
    chk("err", err_at, exp_err);
    chk("writes", wrs, exp_wr);
    chk("busy_cycles", busys, exp_cyc - 1);
    chk("idle_bus", int'(mem_address) + int'(mem_data) + int'(mem_wren), 0);
    if (exp_err == 0)
      for (int i = 0; i < len; i++) ref_mem[dst + i] = ref_mem[src + i];
    for (int i = 0; i <= len && dst + i < DEPTH; i++)
      if (mem[dst + i] != ref_mem[dst + i]) bad++;
    chk("dst_data", bad, 0);
  endtask

  vec_t tbl[$];

  initial begin
    int s, d, l, e;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bus", int'(mem_address) + int'(mem_data) + int'(mem_wren), 0);
    @(negedge clk); rst = 1'b0;

    tbl.push_back('{'h00000, 'h00100, 4, 0, 10, 4});
    tbl.push_back('{'h95FFE, 'h00010, 2, 0, 6, 2});
    tbl.push_back('{'h95FFF, 'h00010, 2, 1, 2, 0});
    tbl.push_back('{'h00020, 'h00030, 0, 0, 2, 0});
    tbl.push_back('{'h00010, 'h95FFF, 2, 1, 2, 0});
    tbl.push_back('{'h00200, 'h95FFC, 4, 0, 10, 4});
    tbl.push_back('{'h00305, 'h00300, 8, 0, 18, 8});
    tbl.push_back('{'h00400, 'h00400, 3, 0, 8, 3});
    foreach (tbl[i])
      run_xfer(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].exp_err, tbl[i].exp_cyc, tbl[i].exp_wr, 0);
    chk("basic_word3", int'(mem['h103]), 'h44);

    // second start in the middle of a length-8 copy must be ignored
    run_xfer('h00600, 'h00700, 8, 0, 18, 8, 5);

    // reset during the third write of a length-6 copy
    start = 1'b1; src_addr = 20'h00800; dst_addr = 20'h00A00; length = 20'd6;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("wr3_active", int'(mem_wren), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_wren", int'(mem_wren), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    for (int i = 0; i < 3; i++) ref_mem['h00A00 + i] = ref_mem['h00800 + i];
    e = 0;
    for (int i = 0; i < 6; i++) if (mem['h00A00 + i] != ref_mem['h00A00 + i]) e++;
    chk("rst_mid_partial", e, 0);
    @(negedge clk);
    chk("rst_mid_no_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    run_xfer('h00810, 'h00B00, 1, 0, 4, 1, 0);

    for (int t = 0; t < 30; t++) begin
      s = ($urandom_range(0, 1) == 1) ? DEPTH - int'($urandom_range(0, 16)) : int'($urandom_range(0, DEPTH - 1));
      d = ($urandom_range(0, 1) == 1) ? DEPTH - int'($urandom_range(0, 16)) : int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) d = s - int'($urandom_range(0, l));
      if (d < 0) d = 0;
      if (d > s && d < s + l) d = s;
      e = (l != 0 && (s + l > DEPTH || d + l > DEPTH)) ? 1 : 0;
      run_xfer(s, d, l, e, (l == 0 || e == 1) ? 2 : 2 * l + 2, (e == 1) ? 0 : l, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
